bomb_scheduler: RTL and testbench

BOMB_SCHEDULER -- requirements
Module: bomb_scheduler

---
 rtl/bomb_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_bomb_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bomb_scheduler.sv
// Shared bomb-slot scheduler for two players: grants/denies drops, runs fuse timers, emits blasts.
// Optional chain reactions between nearby bombs are enabled by defining CHAIN_REACTION_EN.
module bomb_scheduler #(
    parameter int SLOTS          = 4,
    parameter int PER_PLAYER_MAX = 2,
    parameter int FUSE_TICKS     = 3,
    parameter int RANGE          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req_a,
    input  logic       req_b,
    input  logic [7:0] pos_a,
    input  logic [7:0] pos_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       deny_a,
    output logic       deny_b,
    output logic       blast_valid,
    output logic [7:0] blast_pos,
    output logic       blast_owner,
    output logic [2:0] live_a,
    output logic [2:0] live_b
);

    if (SLOTS < 2 || SLOTS > 8 || FUSE_TICKS < 1 || FUSE_TICKS > 7 || RANGE < 0) begin : g_bad_param
        $error("bomb_scheduler: parameter out of range");
    end

    localparam logic [2:0] FUSE_INIT = 3'(FUSE_TICKS);

    logic [SLOTS-1:0] r_valid, r_owner, r_pend;
    logic [7:0]       r_pos  [SLOTS];
    logic [2:0]       r_fuse [SLOTS];
    logic             r_prio;
    logic             r_armed;
    logic             r_gnt_a, r_gnt_b, r_deny_a, r_deny_b;
    logic             r_blast_valid, r_blast_owner;
    logic [7:0]       r_blast_pos;
    logic [2:0]       r_live_a, r_live_b;

    logic [SLOTS-1:0] w_valid_n, w_owner_n, w_pend_n;
    logic [7:0]       w_pos_n  [SLOTS];
    logic [2:0]       w_fuse_n [SLOTS];
    logic             w_found, w_bowner;
    logic [7:0]       w_bpos;
    logic [SLOTS-1:0] w_free1_oh, w_free2_oh, w_slot_s_oh;
    logic             w_free1, w_free2;
    logic             w_hit_a, w_hit_b;
    logic             w_req_f, w_req_s, w_hit_f, w_hit_s, w_lim_f, w_lim_s;
    logic [7:0]       w_pos_f, w_pos_s;
    logic             w_ok_f, w_ok_s, w_ok_a, w_ok_b;
    logic [2:0]       w_live_a_n, w_live_b_n;

`ifdef CHAIN_REACTION_EN
    localparam int         RANGE_CL = (RANGE > 15) ? 15 : RANGE;
    localparam logic [3:0] RANGE_C  = 4'(RANGE_CL);

    function automatic logic f_in_range(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] dx, dy;
        dx = (a[7:4] > b[7:4]) ? a[7:4] - b[7:4] : b[7:4] - a[7:4];
        dy = (a[3:0] > b[3:0]) ? a[3:0] - b[3:0] : b[3:0] - a[3:0];
        return ((a[7:4] == b[7:4]) && (dy <= RANGE_C)) ||
               ((a[3:0] == b[3:0]) && (dx <= RANGE_C));
    endfunction
`endif

    always_comb begin
        w_valid_n = r_valid;
        w_owner_n = r_owner;
        w_pend_n  = r_pend;
        w_pos_n   = r_pos;
        w_fuse_n  = r_fuse;
        w_found   = 1'b0;
        w_bpos    = 8'd0;
        w_bowner  = 1'b0;

        for (int i = 0; i < SLOTS; i++) begin
            if (tick && r_valid[i] && !r_pend[i]) begin
                w_fuse_n[i] = r_fuse[i] - 3'd1;
                if (r_fuse[i] == 3'd1) w_pend_n[i] = 1'b1;
            end
        end

        // A slot expiring on this tick is already eligible for emission on this edge.
        for (int i = 0; i < SLOTS; i++) begin
            if (!w_found && r_valid[i] && w_pend_n[i]) begin
                w_found      = 1'b1;
                w_bpos       = r_pos[i];
                w_bowner     = r_owner[i];
                w_valid_n[i] = 1'b0;
                w_pend_n[i]  = 1'b0;
            end
        end

`ifdef CHAIN_REACTION_EN
        for (int i = 0; i < SLOTS; i++) begin
            if (w_found && w_valid_n[i] && f_in_range(w_bpos, r_pos[i])) w_pend_n[i] = 1'b1;
        end
`endif

        // Allocation sees the current slot state, so a slot freed on this edge is not reusable yet.
        w_free1    = 1'b0;
        w_free2    = 1'b0;
        w_free1_oh = '0;
        w_free2_oh = '0;
        w_hit_a    = 1'b0;
        w_hit_b    = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!r_valid[i]) begin
                if (!w_free1) begin
                    w_free1       = 1'b1;
                    w_free1_oh[i] = 1'b1;
                end else if (!w_free2) begin
                    w_free2       = 1'b1;
                    w_free2_oh[i] = 1'b1;
                end
            end
            if (r_valid[i] && r_pos[i] == pos_a) w_hit_a = 1'b1;
            if (r_valid[i] && r_pos[i] == pos_b) w_hit_b = 1'b1;
        end

        w_req_f = r_prio ? req_b : req_a;
        w_req_s = r_prio ? req_a : req_b;
        w_pos_f = r_prio ? pos_b : pos_a;
        w_pos_s = r_prio ? pos_a : pos_b;
        w_hit_f = r_prio ? w_hit_b : w_hit_a;
        w_hit_s = r_prio ? w_hit_a : w_hit_b;
        w_lim_f = r_prio ? (int'(r_live_b) < PER_PLAYER_MAX) : (int'(r_live_a) < PER_PLAYER_MAX);
        w_lim_s = r_prio ? (int'(r_live_a) < PER_PLAYER_MAX) : (int'(r_live_b) < PER_PLAYER_MAX);

        w_ok_f = r_armed && w_req_f && w_free1 && w_lim_f && !w_hit_f;
        w_ok_s = r_armed && w_req_s && w_lim_s && !w_hit_s &&
                 (w_ok_f ? (w_free2 && (w_pos_s != w_pos_f)) : w_free1);
        w_slot_s_oh = w_ok_f ? w_free2_oh : w_free1_oh;
        w_ok_a = r_prio ? w_ok_s : w_ok_f;
        w_ok_b = r_prio ? w_ok_f : w_ok_s;

        for (int i = 0; i < SLOTS; i++) begin
            if ((w_ok_f && w_free1_oh[i]) || (w_ok_s && w_slot_s_oh[i])) begin
                w_valid_n[i] = 1'b1;
                w_pend_n[i]  = 1'b0;
                w_fuse_n[i]  = FUSE_INIT;
                w_owner_n[i] = (w_ok_f && w_free1_oh[i]) ? r_prio : ~r_prio;
                w_pos_n[i]   = (w_ok_f && w_free1_oh[i]) ? w_pos_f : w_pos_s;
            end
        end

        w_live_a_n = 3'd0;
        w_live_b_n = 3'd0;
        for (int i = 0; i < SLOTS; i++) begin
            if (w_valid_n[i] && !w_owner_n[i]) w_live_a_n = w_live_a_n + 3'd1;
            if (w_valid_n[i] &&  w_owner_n[i]) w_live_b_n = w_live_b_n + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= '0;
            r_owner       <= '0;
            r_pend        <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                r_pos[i]  <= 8'd0;
                r_fuse[i] <= 3'd0;
            end
            r_prio        <= 1'b0;
            r_armed       <= 1'b0;
            r_gnt_a       <= 1'b0;
            r_gnt_b       <= 1'b0;
            r_deny_a      <= 1'b0;
            r_deny_b      <= 1'b0;
            r_blast_valid <= 1'b0;
            r_blast_pos   <= 8'd0;
            r_blast_owner <= 1'b0;
            r_live_a      <= 3'd0;
            r_live_b      <= 3'd0;
        end else begin
            r_valid       <= w_valid_n;
            r_owner       <= w_owner_n;
            r_pend        <= w_pend_n;
            r_pos         <= w_pos_n;
            r_fuse        <= w_fuse_n;
            // Requests held across reset release are dropped on the first edge.
            r_armed       <= 1'b1;
            if (r_armed && req_a && req_b) r_prio <= ~r_prio;
            r_gnt_a       <= w_ok_a;
            r_gnt_b       <= w_ok_b;
            r_deny_a      <= r_armed && req_a && !w_ok_a;
            r_deny_b      <= r_armed && req_b && !w_ok_b;
            r_blast_valid <= w_found;
            r_blast_pos   <= w_bpos;
            r_blast_owner <= w_bowner;
            r_live_a      <= w_live_a_n;
            r_live_b      <= w_live_b_n;
        end
    end

    assign gnt_a       = r_gnt_a;
    assign gnt_b       = r_gnt_b;
    assign deny_a      = r_deny_a;
    assign deny_b      = r_deny_b;
    assign blast_valid = r_blast_valid;
    assign blast_pos   = r_blast_pos;
    assign blast_owner = r_blast_owner;
    assign live_a      = r_live_a;
    assign live_b      = r_live_b;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: vector table with hand-derived expectations, scoreboard queue, reset corner cases.
module tb_bomb_scheduler;

    logic       clk = 1'b0;
    logic       rst, tick, req_a, req_b;
    logic [7:0] pos_a, pos_b;
    logic       gnt_a, gnt_b, deny_a, deny_b, blast_valid, blast_owner;
    logic [7:0] blast_pos;
    logic [2:0] live_a, live_b;

    bomb_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick),
        .req_a(req_a), .req_b(req_b), .pos_a(pos_a), .pos_b(pos_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .deny_a(deny_a), .deny_b(deny_b),
        .blast_valid(blast_valid), .blast_pos(blast_pos), .blast_owner(blast_owner),
        .live_a(live_a), .live_b(live_b)
    );

    always #5 clk = ~clk;

    // gd = {gnt_a, deny_a, gnt_b, deny_b}
    typedef struct {
        logic       ra;
        logic [7:0] pa;
        logic       rb;
        logic [7:0] pb;
        logic       tk;
        logic [3:0] gd;
        logic       bv;
        logic [7:0] bp;
        logic       bo;
        logic [2:0] la;
        logic [2:0] lb;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] gd;
        logic       bv;
        logic [7:0] bp;
        logic       bo;
        logic [2:0] la;
        logic [2:0] lb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t V(logic ra, logic [7:0] pa, logic rb, logic [7:0] pb, logic tk,
                               logic [3:0] gd, logic bv, logic [7:0] bp, logic bo,
                               logic [2:0] la, logic [2:0] lb);
        vec_t v;
        v.ra = ra; v.pa = pa; v.rb = rb; v.pb = pb; v.tk = tk;
        v.gd = gd; v.bv = bv; v.bp = bp; v.bo = bo; v.la = la; v.lb = lb;
        return v;
    endfunction

    task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, id, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got=0 want=1");
            return;
        end
        e = sb.pop_front();
        chk("resp", e.id, 32'({gnt_a, deny_a, gnt_b, deny_b}), 32'(e.gd));
        chk("blast_valid", e.id, 32'(blast_valid), 32'(e.bv));
        if (e.bv) chk("blast_pos_owner", e.id, 32'({blast_pos, blast_owner}), 32'({e.bp, e.bo}));
        chk("live", e.id, 32'({live_a, live_b}), 32'({e.la, e.lb}));
    endtask

    task automatic apply(vec_t v, int id);
        exp_t e;
        req_a = v.ra; pos_a = v.pa; req_b = v.rb; pos_b = v.pb; tick = v.tk;
        e.id = id; e.gd = v.gd; e.bv = v.bv; e.bp = v.bp; e.bo = v.bo; e.la = v.la; e.lb = v.lb;
        sb.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    task automatic chk_all_zero(string nm);
        chk(nm, -1, 32'({gnt_a, gnt_b, deny_a, deny_b, blast_valid, blast_pos, blast_owner, live_a, live_b}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // single drop and fuse
        vecs.push_back(V(1, 8'h23, 0, 8'h00, 0, 4'b1000, 0, 8'h00, 0, 1, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h23, 0, 0, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
        // per-player limit, same-position deny, simultaneous expiry of three
        vecs.push_back(V(1, 8'h11, 0, 8'h00, 0, 4'b1000, 0, 8'h00, 0, 1, 0));
        vecs.push_back(V(1, 8'h12, 0, 8'h00, 0, 4'b1000, 0, 8'h00, 0, 2, 0));
        vecs.push_back(V(1, 8'h13, 0, 8'h00, 0, 4'b0100, 0, 8'h00, 0, 2, 0));
        vecs.push_back(V(0, 8'h00, 1, 8'h11, 0, 4'b0001, 0, 8'h00, 0, 2, 0));
        vecs.push_back(V(0, 8'h00, 1, 8'h14, 0, 4'b0010, 0, 8'h00, 0, 2, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 2, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 2, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h11, 0, 1, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 1, 8'h12, 0, 0, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 1, 8'h14, 1, 0, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
        // conflicts with pointer toggle; grant on a tick edge is not decremented
        vecs.push_back(V(1, 8'h44, 1, 8'h44, 0, 4'b1001, 0, 8'h00, 0, 1, 0));
        vecs.push_back(V(1, 8'h55, 1, 8'h55, 1, 4'b0110, 0, 8'h00, 0, 1, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h44, 0, 0, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h55, 1, 0, 0));
        // fill all slots, reuse only after the freeing edge
        vecs.push_back(V(0, 8'h00, 1, 8'h30, 0, 4'b0010, 0, 8'h00, 0, 0, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 1));
        vecs.push_back(V(1, 8'h51, 1, 8'h72, 0, 4'b1010, 0, 8'h00, 0, 1, 2));
        vecs.push_back(V(1, 8'h93, 0, 8'h00, 0, 4'b1000, 0, 8'h00, 0, 2, 2));
        vecs.push_back(V(0, 8'h00, 1, 8'hB4, 0, 4'b0001, 0, 8'h00, 0, 2, 2));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 2, 2));
        vecs.push_back(V(0, 8'h00, 1, 8'hD5, 1, 4'b0001, 1, 8'h30, 1, 2, 1));
        vecs.push_back(V(0, 8'h00, 1, 8'hD5, 0, 4'b0010, 0, 8'h00, 0, 2, 2));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h51, 0, 1, 2));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h72, 1, 1, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 1, 8'h93, 0, 0, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'hD5, 1, 0, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
        // same-cycle placement with B priority: B takes slot 0 and blasts first
        vecs.push_back(V(1, 8'h70, 1, 8'h71, 0, 4'b1010, 0, 8'h00, 0, 1, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h71, 1, 1, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 1, 8'h70, 0, 0, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
        // 8'h20 with one tick left, 8'h22 freshly placed
        vecs.push_back(V(1, 8'h20, 0, 8'h00, 0, 4'b1000, 0, 8'h00, 0, 1, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 0));
        vecs.push_back(V(0, 8'h00, 1, 8'h22, 0, 4'b0010, 0, 8'h00, 0, 1, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h20, 0, 0, 1));
`ifdef CHAIN_REACTION_EN
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 1, 8'h22, 1, 0, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 0));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 0));
`else
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 1));
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'h22, 1, 0, 0));
`endif
        vecs.push_back(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0, 0));

        rst = 1'b1; tick = 1'b0; req_a = 1'b0; req_b = 1'b0; pos_a = 8'h00; pos_b = 8'h00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");

        // request held through reset release must be ignored
        req_a = 1'b1; pos_a = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("req_at_release", -1, 32'({gnt_a, deny_a, live_a}), 32'd0);
        req_a = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // reset mid-fuse discards the bomb without a blast
        apply(V(1, 8'h90, 0, 8'h00, 0, 4'b1000, 0, 8'h00, 0, 1, 0), 100);
        apply(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 0), 101);
        req_a = 1'b0; req_b = 1'b0; tick = 1'b0;
        rst = 1'b1;
        #1 chk_all_zero("reset_mid_fuse");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) apply(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 0, 0), 110 + k);

        // reset mid-blast-sequence: second pending bomb never blasts
        apply(V(1, 8'hA0, 1, 8'hA1, 0, 4'b1010, 0, 8'h00, 0, 1, 1), 120);
        apply(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 1), 121);
        apply(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 0, 8'h00, 0, 1, 1), 122);
        apply(V(0, 8'h00, 0, 8'h00, 1, 4'b0000, 1, 8'hA0, 0, 0, 1), 123);
        tick = 1'b0;
        rst = 1'b1;
        #1 chk_all_zero("reset_mid_blast");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) apply(V(0, 8'h00, 0, 8'h00, 0, 4'b0000, 0, 8'h00, 0, 0, 0), 130 + k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
